// File: rtl/afifo_wr_pack.sv
// Write-side packer: gathers a byte stream into little-endian NB-byte words
// tagged {last, nbytes-1} and hands them to the async FIFO write port.
module afifo_wr_pack #(
  parameter  int DW   = 8,
  parameter  int LGNB = 2,
  localparam int NB   = 1 << LGNB,
  localparam int OW   = NB * DW + LGNB + 1
) (
  input  logic          wclk,
  input  logic          i_wr_reset_n,
  input  logic          s_valid,
  output logic          s_ready,
  input  logic [DW-1:0] s_data,
  input  logic          s_last,
  output logic          o_wr,
  output logic [OW-1:0] o_wr_data,
  input  logic          i_wr_full,
  output logic [15:0]   o_word_count,
  output logic [15:0]   o_pkt_count
);

  // Handshake: a byte moves when s_valid && s_ready on a rising wclk edge;
  // a word moves into the FIFO when o_wr && !i_wr_full on a rising edge.

  logic [NB*DW-1:0] acc_q, acc_d;
  logic [LGNB-1:0]  cnt_q, cnt_d;
  logic             out_valid_q, out_valid_d;
  logic [OW-1:0]    wr_data_q, wr_data_d;
  logic [15:0]      word_count_q, word_count_d;
  logic [15:0]      pkt_count_q, pkt_count_d;

  logic             accept;
  logic             complete;
  logic             fifo_wr;
  logic [NB*DW-1:0] merged;

  always_comb begin
    s_ready  = !out_valid_q || !i_wr_full;
    accept   = s_valid && s_ready;
    fifo_wr  = out_valid_q && !i_wr_full;
    complete = accept && ((cnt_q == LGNB'(NB - 1)) || s_last);

    // New byte dropped into lane cnt; lanes above it are zeroed for a short word
    merged = acc_q;
    for (int i = 0; i < NB; i++) begin
      if (i == int'(cnt_q)) begin
        merged[i*DW +: DW] = s_data;
      end else if (i > int'(cnt_q)) begin
        merged[i*DW +: DW] = '0;
      end
    end

    acc_d        = acc_q;
    cnt_d        = cnt_q;
    out_valid_d  = out_valid_q;
    wr_data_d    = wr_data_q;
    word_count_d = word_count_q;
    pkt_count_d  = pkt_count_q;

    if (fifo_wr) begin
      out_valid_d  = 1'b0;
      word_count_d = word_count_q + 16'd1;
      if (wr_data_q[OW-1]) begin
        pkt_count_d = pkt_count_q + 16'd1;
      end
    end

    // A completing byte loads the output register even as the old word leaves
    if (accept) begin
      if (complete) begin
        wr_data_d   = {s_last, cnt_q, merged};
        out_valid_d = 1'b1;
        cnt_d       = '0;
        acc_d       = '0;
      end else begin
        acc_d = merged;
        cnt_d = cnt_q + LGNB'(1);
      end
    end
  end

  always_ff @(posedge wclk or negedge i_wr_reset_n) begin
    if (!i_wr_reset_n) begin
      acc_q        <= '0;
      cnt_q        <= '0;
      out_valid_q  <= 1'b0;
      wr_data_q    <= '0;
      word_count_q <= '0;
      pkt_count_q  <= '0;
    end else begin
      acc_q        <= acc_d;
      cnt_q        <= cnt_d;
      out_valid_q  <= out_valid_d;
      wr_data_q    <= wr_data_d;
      word_count_q <= word_count_d;
      pkt_count_q  <= pkt_count_d;
    end
  end

  assign o_wr         = out_valid_q;
  assign o_wr_data    = wr_data_q;
  assign o_word_count = word_count_q;
  assign o_pkt_count  = pkt_count_q;

endmodule

// File: tb/tb_afifo_wr_pack.sv
// Bench for afifo_wr_pack: directed scenarios plus random packets, checked
// against a byte/word queue model of the packing rules.
module tb_afifo_wr_pack;

  localparam int DW   = 8;
  localparam int LGNB = 2;
  localparam int NB   = 1 << LGNB;
  localparam int OW   = NB * DW + LGNB + 1;

  // ---------------- clock / reset ----------------
  logic          wclk = 1'b0;
  logic          i_wr_reset_n = 1'b0;
  logic          s_valid = 1'b0;
  logic          s_ready;
  logic [DW-1:0] s_data = '0;
  logic          s_last = 1'b0;
  logic          o_wr;
  logic [OW-1:0] o_wr_data;
  logic          i_wr_full = 1'b0;
  logic [15:0]   o_word_count;
  logic [15:0]   o_pkt_count;

  always #5 wclk = ~wclk;

  afifo_wr_pack #(.DW(DW), .LGNB(LGNB)) dut (
    .wclk         (wclk),
    .i_wr_reset_n (i_wr_reset_n),
    .s_valid      (s_valid),
    .s_ready      (s_ready),
    .s_data       (s_data),
    .s_last       (s_last),
    .o_wr         (o_wr),
    .o_wr_data    (o_wr_data),
    .i_wr_full    (i_wr_full),
    .o_word_count (o_word_count),
    .o_pkt_count  (o_pkt_count)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_pass   = 0;

  logic [OW-1:0] exp_q[$];   // words the model says are owed to the FIFO, oldest first
  logic [OW-1:0] obs_q[$];   // words actually written since the last reset
  logic [DW-1:0] cur_q[$];   // bytes of the word currently being gathered
  logic [15:0]   m_words = '0;
  logic [15:0]   m_pkts  = '0;
  logic          last_accept = 1'b0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  function automatic logic [OW-1:0] make_word(input logic last);
    logic [OW-1:0] w;
    w = '0;
    for (int k = 0; k < cur_q.size(); k++) w[k*DW +: DW] = cur_q[k];
    w[NB*DW +: LGNB] = LGNB'(cur_q.size() - 1);
    w[OW-1] = last;
    return w;
  endfunction

  // Runs at the falling edge: compares, then advances the model over the coming rising edge
  task automatic model_step();
    logic exp_ready;
    logic fire;
    exp_ready = (exp_q.size() == 0) || !i_wr_full;
    fire      = (exp_q.size() != 0) && !i_wr_full;
    check_eq("o_wr", o_wr, exp_q.size() != 0);
    check_eq("s_ready", s_ready, exp_ready);
    check_eq("word_count", o_word_count, m_words);
    check_eq("pkt_count", o_pkt_count, m_pkts);
    if (fire) begin
      check_eq("wr_data", o_wr_data, exp_q[0]);
      obs_q.push_back(o_wr_data);
      if (exp_q[0][OW-1]) m_pkts = m_pkts + 16'd1;
      m_words = m_words + 16'd1;
      void'(exp_q.pop_front());
    end
    last_accept = s_valid && exp_ready;
    if (last_accept) begin
      cur_q.push_back(s_data);
      if (cur_q.size() == NB || s_last) begin
        exp_q.push_back(make_word(s_last));
        cur_q.delete();
      end
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic cycle(input logic v, input logic [DW-1:0] d, input logic l, input logic f);
    s_valid = v; s_data = d; s_last = l; i_wr_full = f;
    @(negedge wclk);
    model_step();
    @(posedge wclk);
    #1;
  endtask

  task automatic do_reset();
    i_wr_reset_n = 1'b0;
    #1;
    for (int c = 0; c < 3; c++) begin
      s_valid = 1'($urandom_range(1)); s_data = DW'($urandom);
      s_last = 1'($urandom_range(1)); i_wr_full = 1'($urandom_range(1));
      @(negedge wclk);
      check_eq("rst_o_wr", o_wr, 1'b0);
      check_eq("rst_wr_data", o_wr_data, '0);
      check_eq("rst_s_ready", s_ready, 1'b1);
      check_eq("rst_word_count", o_word_count, 16'd0);
      check_eq("rst_pkt_count", o_pkt_count, 16'd0);
      @(posedge wclk);
      #1;
    end
    exp_q.delete(); obs_q.delete(); cur_q.delete();
    m_words = '0; m_pkts = '0;
    s_valid = 1'b0; i_wr_full = 1'b0;
    i_wr_reset_n = 1'b1;
  endtask

  // Offers each byte until accepted; v_pct/f_pct randomise valid gaps and FIFO full
  task automatic send_bytes(input logic [DW-1:0] bytes[$], input logic end_pkt,
                            input int v_pct, input int f_pct);
    for (int i = 0; i < bytes.size(); i++) begin
      int guard = 0;
      do begin
        cycle(($urandom_range(99) < v_pct), bytes[i],
              end_pkt && (i == bytes.size() - 1), ($urandom_range(99) < f_pct));
        guard++;
      end while (!last_accept && guard < 200);
      if (!last_accept) check_eq("accept_timeout", 1'b0, 1'b1);
    end
  endtask

  task automatic flush();
    int guard = 0;
    while (exp_q.size() != 0 && guard < 50) begin
      cycle(1'b0, '0, 1'b0, 1'b0);
      guard++;
    end
    check_eq("flush_done", exp_q.size() == 0, 1'b1);
    cycle(1'b0, '0, 1'b0, 1'b0);
  endtask

  // ---------------- tests ----------------
  initial begin
    logic [DW-1:0] pkt[$];
    logic [OW-1:0] held;

    do_reset();

    // 8-byte packet 0x01..0x08
    pkt = {8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
    send_bytes(pkt, 1'b1, 100, 0);
    flush();
    check_eq("p8_nwrites", obs_q.size(), 2);
    if (obs_q.size() == 2) begin
      check_eq("p8_word0", obs_q[0], {1'b0, 2'd3, 32'h04030201});
      check_eq("p8_word1", obs_q[1], {1'b1, 2'd3, 32'h08070605});
    end
    check_eq("p8_word_count", o_word_count, 16'd2);
    check_eq("p8_pkt_count", o_pkt_count, 16'd1);

    // Short packet
    do_reset();
    pkt = {8'hAA, 8'hBB, 8'hCC};
    send_bytes(pkt, 1'b1, 100, 0);
    flush();
    check_eq("short_nwrites", obs_q.size(), 1);
    if (obs_q.size() == 1) check_eq("short_word", obs_q[0], {1'b1, 2'd2, 32'h00CCBBAA});

    // Backpressure hold for 5 cycles with a byte offered throughout
    do_reset();
    pkt = {8'h41, 8'h42, 8'h43, 8'h44};
    send_bytes(pkt, 1'b0, 100, 0);
    held = o_wr_data;
    check_eq("bp_loaded", o_wr, 1'b1);
    for (int c = 0; c < 5; c++) begin
      cycle(1'b1, 8'h99, 1'b0, 1'b1);
      check_eq("bp_no_accept", last_accept, 1'b0);
      check_eq("bp_data_stable", o_wr_data, held);
      check_eq("bp_o_wr_held", o_wr, 1'b1);
    end
    check_eq("bp_counts_frozen", o_word_count, 16'd0);
    cycle(1'b0, 8'h99, 1'b0, 1'b0);
    check_eq("bp_one_write", o_word_count, 16'd1);
    check_eq("bp_ready_back", s_ready, 1'b1);
    check_eq("bp_word", obs_q.size() == 1 && obs_q[0] == {1'b0, 2'd3, 32'h44434241}, 1'b1);
    flush();

    // Six back-to-back 1-byte packets
    do_reset();
    for (int i = 0; i < 6; i++) begin
      cycle(1'b1, 8'h10 + 8'(i), 1'b1, 1'b0);
      check_eq("b2b_accept", last_accept, 1'b1);
    end
    flush();
    check_eq("b2b_nwrites", obs_q.size(), 6);
    for (int i = 0; i < obs_q.size(); i++)
      check_eq("b2b_word", obs_q[i], {1'b1, 2'd0, 24'h0, 8'h10 + 8'(i)});
    check_eq("b2b_pkt_count", o_pkt_count, 16'd6);

    // Reset mid-word discards the partial bytes
    do_reset();
    pkt = {8'h11, 8'h22};
    send_bytes(pkt, 1'b0, 100, 0);
    do_reset();
    pkt = {8'h31, 8'h32, 8'h33, 8'h34};
    send_bytes(pkt, 1'b1, 100, 0);
    flush();
    check_eq("midrst_nwrites", obs_q.size(), 1);
    if (obs_q.size() == 1) check_eq("midrst_word", obs_q[0], {1'b1, 2'd3, 32'h34333231});

    // Random packets with valid gaps and FIFO backpressure
    do_reset();
    for (int p = 0; p < 40; p++) begin
      int len;
      len = $urandom_range(1, 3 * NB + 1);
      pkt.delete();
      for (int b = 0; b < len; b++) pkt.push_back(DW'($urandom));
      send_bytes(pkt, 1'b1, 75, 30);
    end
    flush();
    check_eq("rand_pkt_count", o_pkt_count, 16'd40);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule

// File: doc/afifo_wr_pack.md
# afifo_wr_pack

Write-side packer that sits directly upstream of the async FIFO, in the write clock domain. It accepts a byte-wide valid/ready/last stream and packs it little-endian into NB-byte words. Each word carries a byte-count and end-of-packet tag. Completed words are presented to the FIFO's write port (write strobe, data, full) through a single-entry output register that honours FIFO backpressure.

## Interface
- DW, 8: bits per input byte lane.
- LGNB, 2: log2 of bytes per packed word; NB = 1<<LGNB (1 ≤ LGNB ≤ 4).
- OW, derived = NB*DW + LGNB + 1: packed word width. Must equal the FIFO WIDTH parameter.
- wclk  in  1  write-side clock; all logic is on its rising edge.
- i_wr_reset_n  in  1  reset, asynchronous, active-low. Shared with the FIFO write side.
- s_valid  in  1  input byte valid.
- s_ready  out  1  input byte accepted when s_valid && s_ready.
- s_data  in  DW  input byte.
- s_last  in  1  marks the final byte of a packet.
- o_wr  out  1  FIFO write request; drives FIFO i_wr.
- o_wr_data  out  OW  packed word, laid out as {last, nbytes-1 [LGNB bits], data [NB*DW bits]}.
- i_wr_full  in  1  FIFO full flag, from FIFO o_wr_full.
- o_word_count  out  16  words written into the FIFO; wraps modulo 2^16.
- o_pkt_count  out  16  words with last=1 written into the FIFO; wraps modulo 2^16.

## Operation
- State: accumulator acc[NB*DW-1:0], byte counter cnt[LGNB-1:0], output register {out_valid, o_wr_data}.
- s_ready = !out_valid || !i_wr_full. This is combinational; i_wr_full is registered inside the FIFO.
- o_wr = out_valid.
- Accepted byte handling:
  - The byte is written into lane cnt of acc, at bits cnt*DW +: DW.
  - Lane 0 holds the first byte, so data is little-endian.
- Word completion: occurs when an accepted byte has cnt == NB-1 or s_last == 1.
  - The output register loads data = acc with the new byte merged in; lanes above cnt are forced to 0.
  - nbytes-1 field = cnt; last field = s_last.
  - out_valid is set to 1, cnt is cleared to 0, and acc is cleared to 0.
- Byte accepted without completion: cnt increments by 1; out_valid is unchanged.
- FIFO write: occurs on any edge where o_wr && !i_wr_full.
  - out_valid clears unless a new word loads on the same edge. Load wins, so the register holds the new word.
  - o_word_count increments by 1. o_pkt_count increments by 1 if the written word's last field = 1.
- While o_wr && i_wr_full:
  - o_wr_data and o_wr are held stable; no bytes are accepted.
  - Partial-word bytes are also stalled. s_ready does not depend on cnt.
- A packet of length L bytes produces ceil(L/NB) words. Only the final word has last=1; every non-final word has nbytes-1 = NB-1.
- Zero-length packets do not exist. Every accepted s_last carries a real byte.
- The block never drops or duplicates a byte, and never writes while i_wr_full = 1.

## Timing
- Reset values while i_wr_reset_n = 0, applied immediately and asynchronously:
  - out_valid = 0, o_wr = 0, o_wr_data = 0, cnt = 0, acc = 0.
  - o_word_count = 0, o_pkt_count = 0, s_ready = 1.
- Latency: a byte that completes a word on edge k gives o_wr = 1 with that word's data from just after edge k. The earliest FIFO write is edge k+1.
- Throughput: one byte per cycle sustained while i_wr_full = 0. Back-to-back 1-byte packets produce one FIFO write per cycle.
- Simultaneous FIFO write and new completion on the same edge: no bubble; o_wr stays 1 with the new data.
- i_wr_full rising while out_valid = 0: s_ready stays 1. Bytes continue to accumulate, and one further completed word may load.
- Reset asserted mid-word or mid-packet: the partial accumulator and any pending output word are discarded. No FIFO write occurs after reset. The downstream packet stream must be resynchronised by the consumer; the FIFO is reset by the same signal.
- Counter wrap: 0xFFFF + 1 → 0x0000, with no flag.

## Test plan
- Reset check: hold i_wr_reset_n = 0 for 3 cycles with random inputs → o_wr = 0, o_wr_data = 0, s_ready = 1, both counters = 0 throughout.
- 8-byte packet 0x01..0x08 streamed, s_last on 0x08, i_wr_full = 0 (DW = 8, LGNB = 2) → two writes.
  - First write: data 0x04030201, nbytes-1 = 3, last = 0.
  - Second write: data 0x08070605, nbytes-1 = 3, last = 1.
  - Ends with o_word_count = 2, o_pkt_count = 1.
- Short packet 0xAA, 0xBB, 0xCC with s_last on 0xCC → one write: data 0x00CCBBAA, nbytes-1 = 2, last = 1.
- Backpressure: complete a word, then hold i_wr_full = 1 for 5 cycles with s_valid = 1.
  - During the hold: o_wr = 1 and o_wr_data stable; s_ready = 0; no byte is consumed; the counters do not change.
  - On the first edge after i_wr_full falls: exactly one write occurs, and s_ready returns to 1.
- Six back-to-back 1-byte packets 0x10..0x15 with i_wr_full = 0 → six consecutive writes, one per cycle.
  - Each write has data = 0x000000XX, nbytes-1 = 0, last = 1.
  - Ends with o_pkt_count = 6.
- Reset mid-word: accept 0x11 and 0x22, pulse reset, then send 0x31..0x34 with s_last on 0x34 → exactly one write: data 0x34333231, last = 1. Neither 0x11 nor 0x22 appears in any write.
